// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment multiplexer.
//   SEG_OFF       - all segments dark (active-low bus)
//   hex_digit_t   - one 4-bit hex digit
//   seg_pattern_t - active-low segment pattern {g,f,e,d,c,b,a}
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef logic [3:0] hex_digit_t;
    typedef logic [6:0] seg_pattern_t;

endpackage

// File: rtl/seven_seg_mux_if.sv
// Bundle of the digit-load inputs and display-pin outputs of seven_seg_mux.
//   load       - capture digits_in/blank_mask into the pending buffer
//   digits_in  - 4*NUM_DIGITS hex digits, digit 0 in the low nibble
//   blank_mask - 1 = digit forced dark
//   seg        - active-low segments {g,f,e,d,c,b,a}
//   an         - active-low anode enables, one-cold at most
//   frame_done - one-cycle pulse at the end of the last digit's slot
// master: digit producer side; slave: the multiplexer.
interface seven_seg_mux_if #(
    parameter int unsigned NUM_DIGITS = 2
);
    import seven_seg_pkg::*;

    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    seg_pattern_t            seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output load, digits_in, blank_mask,
        input  seg, an, frame_done
    );

    modport slave (
        input  load, digits_in, blank_mask,
        output seg, an, frame_done
    );

endinterface

// File: rtl/seven_seg.sv
// Combinational hex-to-seven-segment decoder.
//   digit_i - hex digit 0..F
//   seg_o   - active-low segment pattern {g,f,e,d,c,b,a}
module seven_seg
    import seven_seg_pkg::*;
(
    input  hex_digit_t   digit_i,
    output seg_pattern_t seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        unique case (digit_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits on
// one shared active-low segment bus. Each digit owns a REFRESH_DIV-cycle slot
// whose first DEADTIME cycles are blanked. Loads are double-buffered and only
// committed at the frame boundary so a frame never shows mixed data.
//   clk   - system clock
//   reset - synchronous, active-high reset
//   bus   - seven_seg_mux_if.slave (load/digits_in/blank_mask in,
//           seg/an/frame_done out, all outputs registered)
// Build option: define SEVSEG_LZB_EN for leading-zero blanking of digits > 0.
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 2,
    parameter int unsigned REFRESH_DIV = 24000,
    parameter int unsigned DEADTIME    = 16
) (
    input  logic           clk,
    input  logic           reset,
    seven_seg_mux_if.slave bus
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] DeadCnt = CntW'(DEADTIME);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;

    hex_digit_t [NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
    logic       [NUM_DIGITS-1:0] pend_mask_q, pend_mask_d;
    logic                        pend_valid_q, pend_valid_d;
    hex_digit_t [NUM_DIGITS-1:0] act_dig_q, act_dig_d;
    logic       [NUM_DIGITS-1:0] act_mask_q, act_mask_d;

    seg_pattern_t          seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  slot_end;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [NUM_DIGITS-1:0] dark;
    hex_digit_t            digit_sel;
    seg_pattern_t          seg_dec;

    // Slot counter and digit index.
    always_comb begin
        slot_end  = (cnt_q == CntLast);
        frame_end = slot_end && (idx_q == IdxLast);
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end
    end

    // Double buffer: a load on the commit edge bypasses pending entirely.
    always_comb begin
        pend_dig_d   = pend_dig_q;
        pend_mask_d  = pend_mask_q;
        pend_valid_d = pend_valid_q;
        act_dig_d    = act_dig_q;
        act_mask_d   = act_mask_q;
        if (frame_end) begin
            pend_valid_d = 1'b0;
            if (bus.load) begin
                act_dig_d  = bus.digits_in;
                act_mask_d = bus.blank_mask;
            end else if (pend_valid_q) begin
                act_dig_d  = pend_dig_q;
                act_mask_d = pend_mask_q;
            end
        end else if (bus.load) begin
            pend_dig_d   = bus.digits_in;
            pend_mask_d  = bus.blank_mask;
            pend_valid_d = 1'b1;
        end
    end

`ifdef SEVSEG_LZB_EN
    // Digit i > 0 goes dark while it and every higher digit are zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run    = zero_run && (act_dig_q[i] == 4'h0);
            lz_blank[i] = zero_run;
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign dark      = act_mask_q | lz_blank;
    assign digit_sel = act_dig_q[idx_q];

    seven_seg u_dec (
        .digit_i (digit_sel),
        .seg_o   (seg_dec)
    );

    // Outputs are computed from the current counter state and registered, so
    // seg and an always switch together on one edge.
    always_comb begin
        seg_d        = SEG_OFF;
        an_d         = '1;
        frame_done_d = frame_end;
        if ((cnt_q >= DeadCnt) && !dark[idx_q]) begin
            seg_d       = seg_dec;
            an_d[idx_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_dig_q   <= '0;
            pend_mask_q  <= '0;
            pend_valid_q <= 1'b0;
            act_dig_q    <= '0;
            act_mask_q   <= '1;
            seg_q        <= SEG_OFF;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_dig_q   <= pend_dig_d;
            pend_mask_q  <= pend_mask_d;
            pend_valid_q <= pend_valid_d;
            act_dig_q    <= act_dig_d;
            act_mask_q   <= act_mask_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed, table-driven bench for seven_seg_mux with NUM_DIGITS=2,
// REFRESH_DIV=8, DEADTIME=2. Every output is compared on every cycle against
// the frame/slot position derived from the bench's own cycle count.
module tb_seven_seg_mux;

    localparam int unsigned ND = 2;
    localparam int unsigned RD = 8;
    localparam int unsigned DT = 2;
    localparam int FRAME = ND * RD;

    localparam logic [6:0] OFF  = 7'b1111111;
    localparam logic [6:0] S_0  = 7'b1000000;
    localparam logic [6:0] S_2  = 7'b0100100;
    localparam logic [6:0] S_3  = 7'b0110000;
    localparam logic [6:0] S_5  = 7'b0010010;
    localparam logic [6:0] S_A  = 7'b0001000;
    localparam logic [6:0] S_F  = 7'b0001110;

    logic clk = 1'b0;
    logic reset;
    int   cyc;
    int   n_pass;
    int   n_total;

    seven_seg_mux_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_mux #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .DEADTIME    (DT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dig_a;
        int         ld_a;
        logic [7:0] dig_b;
        int         ld_b;
        logic [1:0] mask;
        logic [6:0] seg0;
        logic [1:0] an0;
        logic [6:0] seg1;
        logic [1:0] an1;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Expected outputs after edge cyc for a frame showing (s0,a0)/(s1,a1).
    task automatic check_cycle(input logic [6:0] s0, input logic [1:0] a0,
                               input logic [6:0] s1, input logic [1:0] a1);
        int pos;
        int slot;
        int c;
        logic [6:0] es;
        logic [1:0] ea;
        pos  = (cyc - 1) % FRAME;
        slot = pos / RD;
        c    = pos % RD;
        if (c < DT) begin
            es = OFF;
            ea = 2'b11;
        end else begin
            es = (slot == 1) ? s1 : s0;
            ea = (slot == 1) ? a1 : a0;
        end
        chk("seg", {1'b0, bus.seg}, {1'b0, es});
        chk("an", {6'b0, bus.an}, {6'b0, ea});
        chk("frame_done", {7'b0, bus.frame_done}, {7'b0, (cyc % FRAME) == 0});
    endtask

    // One full frame; loads fire on the edge of tick la and/or lb (-1 = none).
    task automatic run_frame(input logic [6:0] s0, input logic [1:0] a0,
                             input logic [6:0] s1, input logic [1:0] a1,
                             input int la, input logic [7:0] da,
                             input int lb, input logic [7:0] db,
                             input logic [1:0] m);
        for (int i = 0; i < FRAME; i++) begin
            bus.load       = (i == la) || (i == lb);
            bus.digits_in  = (i == lb) ? db : da;
            bus.blank_mask = m;
            tick();
            bus.load = 1'b0;
            check_cycle(s0, a0, s1, a1);
        end
    endtask

    initial begin
        logic [6:0] ps0, ps1;
        logic [1:0] pa0, pa1;
        n_pass  = 0;
        n_total = 0;
        cyc     = 0;

        vecs[0] = '{8'h3A, 4, 8'h00, -1, 2'b00, S_A, 2'b10, S_3, 2'b01};
        vecs[1] = '{8'h7F, 4, 8'h00, -1, 2'b10, S_F, 2'b10, OFF, 2'b11};
        vecs[2] = '{8'h11, 3, 8'h22, 9, 2'b00, S_2, 2'b10, S_2, 2'b01};
        vecs[3] = '{8'h55, 15, 8'h00, -1, 2'b00, S_5, 2'b10, S_5, 2'b01};
`ifdef SEVSEG_LZB_EN
        vecs[4] = '{8'h05, 6, 8'h00, -1, 2'b00, S_5, 2'b10, OFF, 2'b11};
        vecs[5] = '{8'h00, 6, 8'h00, -1, 2'b00, S_0, 2'b10, OFF, 2'b11};
`else
        vecs[4] = '{8'h05, 6, 8'h00, -1, 2'b00, S_5, 2'b10, S_0, 2'b01};
        vecs[5] = '{8'h00, 6, 8'h00, -1, 2'b00, S_0, 2'b10, S_0, 2'b01};
`endif

        // Reset hold.
        reset          = 1'b1;
        bus.load       = 1'b0;
        bus.digits_in  = '0;
        bus.blank_mask = '0;
        repeat (3) tick();
        chk("rst_seg", {1'b0, bus.seg}, {1'b0, OFF});
        chk("rst_an", {6'b0, bus.an}, 8'h03);
        chk("rst_fd", {7'b0, bus.frame_done}, 8'h00);
        reset = 1'b0;
        cyc   = 0;

        // First frame is dark: mask resets to all ones.
        run_frame(OFF, 2'b11, OFF, 2'b11, -1, 8'h00, -1, 8'h00, 2'b00);

        ps0 = OFF; pa0 = 2'b11; ps1 = OFF; pa1 = 2'b11;
        for (int v = 0; v < 6; v++) begin
            // Frame carrying the load still shows the previous contents.
            run_frame(ps0, pa0, ps1, pa1, vecs[v].ld_a, vecs[v].dig_a,
                      vecs[v].ld_b, vecs[v].dig_b, vecs[v].mask);
            run_frame(vecs[v].seg0, vecs[v].an0, vecs[v].seg1, vecs[v].an1,
                      -1, 8'h00, -1, 8'h00, 2'b00);
            ps0 = vecs[v].seg0; pa0 = vecs[v].an0;
            ps1 = vecs[v].seg1; pa1 = vecs[v].an1;
        end

        // Mid-frame reset discards a pending load and darkens the display.
        for (int i = 0; i < 7; i++) begin
            bus.load       = (i == 2);
            bus.digits_in  = 8'h99;
            bus.blank_mask = 2'b00;
            tick();
            bus.load = 1'b0;
        end
        reset = 1'b1;
        tick();
        tick();
        chk("midrst_seg", {1'b0, bus.seg}, {1'b0, OFF});
        chk("midrst_an", {6'b0, bus.an}, 8'h03);
        chk("midrst_fd", {7'b0, bus.frame_done}, 8'h00);
        reset = 1'b0;
        cyc   = 0;
        run_frame(OFF, 2'b11, OFF, 2'b11, -1, 8'h00, -1, 8'h00, 2'b00);
        run_frame(OFF, 2'b11, OFF, 2'b11, -1, 8'h00, -1, 8'h00, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
